seq_divider: RTL

- Multi-cycle unsigned restoring divider, N-bit dividend by N-bit divisor.
- Sequences one shared (N+1)-bit ripple-carry subtractor (an rca_Nbit instance with inverted subtrahend and cin=1), one quotient bit per clock.
- Sits beside the combinational adder/subtractor blocks as the first sequenced arithmetic unit.
- Valid/ready handshake on both input and output.

---
 rtl/seq_divider.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A single ripple-carry subtractor is shared across all iterations.

module rca_Nbit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[W];

endmodule

module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [N:0]    r, r_n;
    logic [N-1:0]  q, q_n;
    logic [N-1:0]  d, d_n;
    logic [CW-1:0] count, count_n;
    logic [N-1:0]  quo_n, rem_n;
    logic          dz_n;

    logic [N:0] s;
    logic [N:0] t;
    logic       no_borrow;

    // R never exceeds D, so its top bit is always shifted out as zero
    logic unused_r_msb;
    assign unused_r_msb = r[N];

    assign s = {r[N-1:0], q[N-1]};

    rca_Nbit #(
        .W(N + 1)
    ) u_sub (
        .a   (s),
        .b   (~{1'b0, d}),
        .cin (1'b1),
        .sum (t),
        .cout(no_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        r_n     = r;
        q_n     = q;
        d_n     = d;
        count_n = count;
        quo_n   = quotient;
        rem_n   = remainder;
        dz_n    = div_by_zero;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quo_n   = '1;
                        rem_n   = dividend;
                        dz_n    = 1'b1;
                        state_n = DONE;
                    end else begin
                        r_n     = '0;
                        q_n     = dividend;
                        d_n     = divisor;
                        count_n = '0;
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                if (no_borrow) begin
                    r_n = t;
                    q_n = {q[N-2:0], 1'b1};
                end else begin
                    r_n = s;
                    q_n = {q[N-2:0], 1'b0};
                end
                count_n = count + CW'(1);
                if (count == LAST) begin
                    quo_n   = q_n;
                    rem_n   = r_n[N-1:0];
                    dz_n    = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r           <= r_n;
            q           <= q_n;
            d           <= d_n;
            count       <= count_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dz_n;
            in_ready    <= (state_n == IDLE);
            out_valid   <= (state_n == DONE);
            busy        <= (state_n == RUN);
        end
    end

endmodule
